// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD character arbiter.
//   ASCII codes, cursor width, default cycle budgets, FSM state encoding.
package lcd_pkg;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam int LCD_POS_W = 5;
   localparam int DEF_INIT_CYCLES = 3000000;
   localparam int DEF_CHAR_CYCLES = 16000;
   localparam int DEF_BS_CYCLES = 32000;
   localparam int DEF_CNT_W = 22;
   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_STROBE, ST_HOLD} lcd_state_e;
endpackage

// File: rtl/lcd_char_arbiter_if.sv
// lcd_char_arbiter_if: bundle of the two source handshakes and the LCD writer side.
//   slave  : the arbiter (takes valid/data, drives ready, lcd_*, busy, cursor_pos, last_grant)
//   master : the environment driving the sources and observing the LCD side
interface lcd_char_arbiter_if;
   import lcd_pkg::*;
   logic                 a_valid;
   logic [7:0]           a_data;
   logic                 a_ready;
   logic                 b_valid;
   logic [7:0]           b_data;
   logic                 b_ready;
   logic [7:0]           lcd_ascii;
   logic                 lcd_ds;
   logic                 busy;
   logic [LCD_POS_W-1:0] cursor_pos;
   logic                 last_grant;
   modport slave (
      input  a_valid, a_data, b_valid, b_data,
      output a_ready, b_ready, lcd_ascii, lcd_ds, busy, cursor_pos, last_grant
   );
   modport master (
      output a_valid, a_data, b_valid, b_data,
      input  a_ready, b_ready, lcd_ascii, lcd_ds, busy, cursor_pos, last_grant
   );
endinterface

// File: rtl/lcd_hold_timer.sv
// lcd_hold_timer: load/decrement counter shared by the init wait and the per-character hold.
//   clk, reset_n : clock, async active-low reset (counter resets to INIT_VAL)
//   load_i       : load load_val_i (has priority over dec_i)
//   dec_i        : decrement by one
//   done_o       : counter currently reads 1, i.e. this is the last cycle of the wait
module lcd_hold_timer #(
   parameter int CNT_W    = 22,
   parameter int INIT_VAL = 3000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             done_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - CNT_W'(1) : cnt_q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= CNT_W'(INIT_VAL);
      else          cnt_q <= cnt_d;

   assign done_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/lcd_char_arbiter.sv
// lcd_char_arbiter: shares one LCD character writer between sources A and B with
//   round-robin arbitration, fixed-budget pacing and a shadow of the LCD cursor.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : source A/B valid/data/ready, lcd_ascii/lcd_ds to the writer,
//                  busy, cursor_pos and last_grant status
module lcd_char_arbiter
   import lcd_pkg::*;
#(
   parameter int INIT_CYCLES = DEF_INIT_CYCLES,
   parameter int CHAR_CYCLES = DEF_CHAR_CYCLES,
   parameter int BS_CYCLES   = DEF_BS_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input logic               clk,
   input logic               reset_n,
   lcd_char_arbiter_if.slave bus
);
   lcd_state_e           state_q, state_d;
   logic [7:0]           ascii_q, ascii_d;
   logic [LCD_POS_W-1:0] cursor_q, cursor_d;
   logic                 last_q, last_d;
   logic                 ds_q, busy_q;
   logic                 idle, grant_b, xfer, drop, strobe_bs, done;
   logic [7:0]           data;

   // On a tie, serve whichever source was not served last.
   assign idle      = state_q == ST_IDLE;
   assign grant_b   = bus.b_valid & (~bus.a_valid | ~last_q);
   assign xfer      = idle & (bus.a_valid | bus.b_valid);
   assign data      = grant_b ? bus.b_data : bus.a_data;
   // Backspace at column 0 is swallowed so the LCD address never wraps backwards.
   assign drop      = data == ASCII_BS && cursor_q == '0;
   assign strobe_bs = ascii_q == ASCII_BS;

   lcd_hold_timer #(.CNT_W(CNT_W), .INIT_VAL(INIT_CYCLES)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (state_q == ST_STROBE),
      .load_val_i(strobe_bs ? CNT_W'(BS_CYCLES) : CNT_W'(CHAR_CYCLES)),
      .dec_i     (state_q == ST_INIT || state_q == ST_HOLD),
      .done_o    (done)
   );

   always_comb begin
      state_d  = state_q;
      ascii_d  = ascii_q;
      cursor_d = cursor_q;
      last_d   = last_q;
      case (state_q)
         ST_INIT:   state_d = done ? ST_IDLE : ST_INIT;
         ST_IDLE:
            if (xfer) begin
               last_d = grant_b;
               if (!drop) begin
                  state_d = ST_STROBE;
                  ascii_d = data;
               end
            end
         ST_STROBE: begin
            state_d  = ST_HOLD;
            cursor_d = strobe_bs ? cursor_q - 1'b1 : cursor_q + 1'b1;
         end
         ST_HOLD:   state_d = done ? ST_IDLE : ST_HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q  <= ST_INIT;
         ascii_q  <= 8'h00;
         cursor_q <= '0;
         last_q   <= 1'b1;
         ds_q     <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         ascii_q  <= ascii_d;
         cursor_q <= cursor_d;
         last_q   <= last_d;
         ds_q     <= state_d == ST_STROBE;
         busy_q   <= state_d != ST_IDLE;
      end

   assign bus.a_ready    = idle & bus.a_valid & ~grant_b;
   assign bus.b_ready    = idle & grant_b;
   assign bus.lcd_ascii  = ascii_q;
   assign bus.lcd_ds     = ds_q;
   assign bus.busy       = busy_q;
   assign bus.cursor_pos = cursor_q;
   assign bus.last_grant = last_q;
endmodule

// File: tb/tb_lcd_char_arbiter.sv
// tb_lcd_char_arbiter: directed bench for lcd_char_arbiter with short cycle budgets.
module tb_lcd_char_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   lcd_char_arbiter_if bus ();

   lcd_char_arbiter #(
      .INIT_CYCLES(20),
      .CHAR_CYCLES(10),
      .BS_CYCLES  (25),
      .CNT_W      (22)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int limit, output int n);
      n = 0;
      #1;
      while (!(bus.a_ready || bus.b_ready) && n < limit) begin
         @(posedge clk);
         #2;
         n++;
      end
   endtask

   task automatic wait_strobe(input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.lcd_ds && n < limit);
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("rst ascii", bus.lcd_ascii, 8'h00);
      check("rst ds", bus.lcd_ds, 1'b0);
      check("rst busy", bus.busy, 1'b1);
      check("rst cursor", bus.cursor_pos, 5'd0);
      check("rst last_grant", bus.last_grant, 1'b1);
      check("rst a_ready", bus.a_ready, 1'b0);
      check("rst b_ready", bus.b_ready, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int n;
      int bad;
      int hold_total;
      logic [7:0] d;
      bus.a_valid = 1'b0;
      bus.a_data  = 8'h00;
      bus.b_valid = 1'b0;
      bus.b_data  = 8'h00;

      // 1: first character waits out init
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h41;
      do_reset();
      wait_ready(100, n);
      check("t1 ready latency", n, 20);
      check("t1 a_ready", bus.a_ready, 1'b1);
      check("t1 b_ready", bus.b_ready, 1'b0);
      step();
      bus.a_valid = 1'b0;
      check("t1 ds", bus.lcd_ds, 1'b1);
      check("t1 ascii", bus.lcd_ascii, 8'h41);
      step();
      check("t1 ds one cycle", bus.lcd_ds, 1'b0);
      check("t1 cursor", bus.cursor_pos, 5'd1);
      check("t1 busy hold", bus.busy, 1'b1);

      // 2: both sources contend, grants alternate
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h31;
      bus.b_valid = 1'b1;
      bus.b_data  = 8'h32;
      do_reset();
      wait_strobe(100, n);
      check("t2 first strobe", n, 21);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            wait_strobe(100, n);
            check("t2 spacing", n, 12);
         end
         check("t2 ascii", bus.lcd_ascii, (k % 2) ? 8'h32 : 8'h31);
         check("t2 last_grant", bus.last_grant, k % 2);
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;

      // 3: character then backspace
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h41;
      do_reset();
      wait_ready(100, n);
      step();
      bus.a_data = 8'h08;
      wait_ready(100, n);
      check("t3 char spacing", n, 11);
      step();
      bus.a_valid = 1'b0;
      check("t3 bs ds", bus.lcd_ds, 1'b1);
      check("t3 bs ascii", bus.lcd_ascii, 8'h08);
      check("t3 cursor before", bus.cursor_pos, 5'd1);
      step();
      check("t3 cursor after", bus.cursor_pos, 5'd0);
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h42;
      wait_ready(100, n);
      check("t3 bs hold", n, 25);
      step();
      bus.a_valid = 1'b0;
      check("t3 next ascii", bus.lcd_ascii, 8'h42);

      // 4: backspace at column 0 is dropped
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h08;
      do_reset();
      wait_ready(100, n);
      check("t4 ready", bus.a_ready, 1'b1);
      step();
      bus.a_valid = 1'b0;
      check("t4 no ds", bus.lcd_ds, 1'b0);
      check("t4 busy", bus.busy, 1'b0);
      check("t4 cursor", bus.cursor_pos, 5'd0);
      check("t4 last_grant", bus.last_grant, 1'b0);
      step();
      check("t4 no ds later", bus.lcd_ds, 1'b0);

      // 5: 33 characters, cursor wrap, stable data in hold
      do_reset();
      bad = 0;
      hold_total = 0;
      for (int k = 0; k < 33; k++) begin
         d = 8'h41 + 8'(k % 26);
         bus.a_data  = d;
         bus.a_valid = 1'b1;
         wait_ready(100, n);
         step();
         bus.a_valid = 1'b0;
         check("t5 ds", bus.lcd_ds, 1'b1);
         check("t5 ascii", bus.lcd_ascii, d);
         n = 0;
         step();
         check("t5 cursor", bus.cursor_pos, (k + 1) % 32);
         while (bus.busy && n < 100) begin
            if (bus.lcd_ascii !== d || bus.lcd_ds !== 1'b0) bad++;
            n++;
            step();
         end
         hold_total += n;
      end
      check("t5 hold stable", bad, 0);
      check("t5 hold cycles", hold_total, 330);

      // 6: reset during hold aborts immediately
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h5A;
      wait_ready(100, n);
      step();
      bus.a_data = 8'h51;
      step();
      step();
      check("t6 cursor pre", bus.cursor_pos, 5'd2);
      check("t6 busy pre", bus.busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("t6 ds", bus.lcd_ds, 1'b0);
      check("t6 cursor", bus.cursor_pos, 5'd0);
      check("t6 busy", bus.busy, 1'b1);
      check("t6 ascii", bus.lcd_ascii, 8'h00);
      check("t6 a_ready", bus.a_ready, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_strobe(100, n);
      check("t6 strobe after release", n, 21);
      check("t6 ascii after", bus.lcd_ascii, 8'h51);
      bus.a_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
